sw_mode_conditioner: RTL and testbench

//  Upstream stage of the LED pattern generator.
//  - Synchronises and debounces the 4 board switches.
//  - Validates the switch code against the legal pattern-mode set.
//  - Drives the generator's mode, a one-cycle mode-change strobe and the pattern step tick.
//  - Replaces the generator's raw switch input and free-running clock divider.

---
 rtl/sw_mode_conditioner_pkg.sv | 31 +++
 rtl/sw_mode_conditioner_step_tick_gen.sv | 43 ++++
 rtl/sw_mode_conditioner.sv | 113 +++++++++++
 tb/tb_sw_mode_conditioner.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sw_mode_conditioner_pkg.sv
// Shared definitions for the switch-mode conditioner and the LED pattern generator:
// legal mode codes, their validity check, and the debounce FSM state encoding.
package sw_mode_conditioner_pkg;

  localparam logic [3:0] MODE_IDLE    = 4'b0000;
  localparam logic [3:0] MODE_SHIFT1  = 4'b1000;
  localparam logic [3:0] MODE_SHIFT2  = 4'b0100;
  localparam logic [3:0] MODE_SHIFT3  = 4'b0010;
  localparam logic [3:0] MODE_SHIFT4  = 4'b0001;
  localparam logic [3:0] MODE_PAIR1   = 4'b1100;
  localparam logic [3:0] MODE_PAIR2   = 4'b1010;
  localparam logic [3:0] MODE_PAIR3   = 4'b1001;
  localparam logic [3:0] MODE_TRIPLE1 = 4'b1110;
  localparam logic [3:0] MODE_TRIPLE2 = 4'b1101;

  typedef enum logic {
    ST_STABLE = 1'b0,
    ST_SETTLE = 1'b1
  } deb_state_e;

  function automatic logic is_legal_mode(input logic [3:0] code);
    case (code)
      MODE_IDLE, MODE_SHIFT1, MODE_SHIFT2, MODE_SHIFT3, MODE_SHIFT4,
      MODE_PAIR1, MODE_PAIR2, MODE_PAIR3, MODE_TRIPLE1, MODE_TRIPLE2:
        is_legal_mode = 1'b1;
      default:
        is_legal_mode = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/sw_mode_conditioner_step_tick_gen.sv
// Pattern step prescaler: free-running 0..STEP_DIV-1 counter with a registered tick
// on the terminal count and a synchronous clear that restarts the step period.
module step_tick_gen #(
  parameter int STEP_DIV = 10_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int             PW     = $clog2(STEP_DIV);
  localparam logic [PW-1:0]  P_LAST = PW'(STEP_DIV - 1);
  localparam logic [PW-1:0]  P_ONE  = PW'(1);

  logic [PW-1:0] r_cnt;
  logic [PW-1:0] w_cnt_nxt;
  logic          r_clr_d;
  logic          r_tick;

  // clr is a one-cycle look-ahead: the tick is suppressed in the following cycle
  // and the count restarts from zero the cycle after that.
  always_comb begin
    if (r_clr_d || (r_cnt == P_LAST)) w_cnt_nxt = '0;
    else                              w_cnt_nxt = r_cnt + P_ONE;
  end

  // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_clr_d <= 1'b0;
      r_tick  <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_clr_d <= clr;
      r_tick  <= !clr && (w_cnt_nxt == P_LAST);
    end
  end

  assign tick = r_tick;

endmodule

// File: rtl/sw_mode_conditioner.sv
// Synchronises and debounces the board switches, validates the code and drives the
// pattern generator's mode, mode-change strobe and step tick.
module sw_mode_conditioner
  import sw_mode_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int STEP_DIV        = 10_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sw,
  output logic [3:0] mode,
  output logic       mode_chg,
  output logic       step_tick,
  output logic       illegal
);

  localparam int             CW       = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

  logic [3:0]    r_s1;
  logic [3:0]    r_s2;
  logic [3:0]    r_cand;
  logic [CW-1:0] r_cnt;
  deb_state_e    r_state;
  logic [3:0]    r_mode;
  logic          r_mode_chg;
  logic          r_illegal;

  logic [3:0]    w_cand_nxt;
  logic [CW-1:0] w_cnt_nxt;
  deb_state_e    w_state_nxt;
  logic [3:0]    w_mode_nxt;
  logic          w_chg_nxt;
  logic          w_illegal_nxt;
  logic          w_commit;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1       <= '0;
      r_s2       <= '0;
      r_cand     <= '0;
      r_cnt      <= '0;
      r_state    <= ST_STABLE;
      r_mode     <= MODE_IDLE;
      r_mode_chg <= 1'b0;
      r_illegal  <= 1'b0;
    end else begin
      r_s1       <= sw;
      r_s2       <= r_s1;
      r_cand     <= w_cand_nxt;
      r_cnt      <= w_cnt_nxt;
      r_state    <= w_state_nxt;
      r_mode     <= w_mode_nxt;
      r_mode_chg <= w_chg_nxt;
      r_illegal  <= w_illegal_nxt;
    end
  end

  // NOTE: every signal gets a hold/default value first so no path through this block infers a latch.
  always_comb begin
    w_cand_nxt    = r_cand;
    w_cnt_nxt     = r_cnt;
    w_state_nxt   = r_state;
    w_mode_nxt    = r_mode;
    w_illegal_nxt = r_illegal;
    w_chg_nxt     = 1'b0;
    w_commit      = 1'b0;

    // Any bounce restarts the window, including one back to the committed code.
    if (r_s2 != r_cand) begin
      w_cand_nxt  = r_s2;
      w_cnt_nxt   = '0;
      w_state_nxt = ST_SETTLE;
    end else if (r_state == ST_SETTLE) begin
      if (r_cnt == CNT_LAST) begin
        w_commit    = 1'b1;
        w_state_nxt = ST_STABLE;
      end else begin
        w_cnt_nxt = r_cnt + CNT_ONE;
      end
    end

    if (w_commit) begin
      if (is_legal_mode(r_cand)) begin
        w_illegal_nxt = 1'b0;
        if (r_cand != r_mode) begin
          w_mode_nxt = r_cand;
          w_chg_nxt  = 1'b1;
        end
      end else begin
        w_illegal_nxt = 1'b1;
      end
    end
  end

  // Fed with the next-cycle strobe so the tick stays a pure flop output yet is
  // still suppressed in the very cycle mode_chg is high.
  step_tick_gen #(
    .STEP_DIV (STEP_DIV)
  ) u_step_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .clr  (w_chg_nxt),
    .tick (step_tick)
  );

  assign mode     = r_mode;
  assign mode_chg = r_mode_chg;
  assign illegal  = r_illegal;

endmodule

// File: tb/tb_sw_mode_conditioner.sv
// Directed bench for sw_mode_conditioner with DEBOUNCE_CYCLES=4, STEP_DIV=8:
// inputs driven and outputs sampled on the falling edge.
module tb_sw_mode_conditioner;

  localparam int DEB = 4;
  localparam int DIV = 8;
  localparam int LAT = DEB + 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] sw  = 4'b0000;
  logic [3:0] mode;
  logic       mode_chg;
  logic       step_tick;
  logic       illegal;

  int n_checks   = 0;
  int n_errors   = 0;
  int tick_total = 0;
  int chg_total  = 0;

  always #5 clk = ~clk;

  sw_mode_conditioner #(
    .DEBOUNCE_CYCLES (DEB),
    .STEP_DIV        (DIV)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sw        (sw),
    .mode      (mode),
    .mode_chg  (mode_chg),
    .step_tick (step_tick),
    .illegal   (illegal)
  );

  // Counts the pulses of the cycle that is ending at each rising edge.
  always @(posedge clk) begin
    if (!rst) begin
      if (step_tick) tick_total++;
      if (mode_chg)  chg_total++;
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // {mode, mode_chg, step_tick, illegal}
  function automatic logic [6:0] obs_all();
    return {mode, mode_chg, step_tick, illegal};
  endfunction

  // {mode, mode_chg, illegal}
  function automatic logic [5:0] obs_mci();
    return {mode, mode_chg, illegal};
  endfunction

  task automatic test_reset();
    logic [6:0] exp;
    rst = 1'b1;
    sw  = 4'b0000;
    step(3);
    n_checks++;
    if (obs_all() !== 7'b0000_0_0_0) begin
      n_errors++;
      $display("FAIL reset_values: got %b expected %b", obs_all(), 7'b0000_0_0_0);
    end
    rst = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      step(1);
      exp = {4'b0000, 1'b0, ((i == 7) || (i == 15)), 1'b0};
      n_checks++;
      if (obs_all() !== exp) begin
        n_errors++;
        $display("FAIL idle_tick cycle %0d: got %b expected %b", i, obs_all(), exp);
      end
    end
  endtask

  task automatic test_first_mode();
    logic [6:0] exp;
    sw = 4'b1000;
    for (int i = 1; i <= LAT; i++) begin
      step(1);
      exp = (i == LAT) ? 7'b1000_1_0_0 : 7'b0000_0_0_0;
      n_checks++;
      if (obs_all() !== exp) begin
        n_errors++;
        $display("FAIL commit_1000 cycle %0d: got %b expected %b", i, obs_all(), exp);
      end
    end
    for (int j = 1; j <= DIV; j++) begin
      step(1);
      exp = {4'b1000, 1'b0, (j == DIV), 1'b0};
      n_checks++;
      if (obs_all() !== exp) begin
        n_errors++;
        $display("FAIL tick_after_chg cycle %0d: got %b expected %b", j, obs_all(), exp);
      end
    end
  endtask

  task automatic test_bounce_to_new();
    logic [5:0] exp;
    int         chg0;
    chg0 = chg_total;
    for (int p = 0; p < 4; p++) begin
      sw = (p % 2 == 0) ? 4'b0100 : 4'b0000;
      for (int k = 0; k < 2; k++) begin
        step(1);
        n_checks++;
        if (obs_mci() !== 6'b1000_0_0) begin
          n_errors++;
          $display("FAIL bounce_hold phase %0d: got %b expected %b", p, obs_mci(), 6'b1000_0_0);
        end
      end
    end
    sw = 4'b0100;
    for (int i = 1; i <= LAT; i++) begin
      step(1);
      exp = (i == LAT) ? 6'b0100_1_0 : 6'b1000_0_0;
      n_checks++;
      if (obs_mci() !== exp) begin
        n_errors++;
        $display("FAIL bounce_commit cycle %0d: got %b expected %b", i, obs_mci(), exp);
      end
    end
    step(3);
    n_checks++;
    if (chg_total - chg0 !== 1) begin
      n_errors++;
      $display("FAIL bounce_chg_count: got %0d expected 1", chg_total - chg0);
    end
  endtask

  task automatic test_illegal();
    logic [5:0] exp;
    int         t0;
    int         c0;
    c0 = chg_total;
    t0 = tick_total;
    sw = 4'b0110;
    for (int i = 1; i <= LAT; i++) begin
      step(1);
      exp = (i == LAT) ? 6'b0100_0_1 : 6'b0100_0_0;
      n_checks++;
      if (obs_mci() !== exp) begin
        n_errors++;
        $display("FAIL illegal_commit cycle %0d: got %b expected %b", i, obs_mci(), exp);
      end
    end
    t0 = tick_total;
    step(16);
    n_checks++;
    if (tick_total - t0 !== 2) begin
      n_errors++;
      $display("FAIL illegal_ticks: got %0d ticks expected 2", tick_total - t0);
    end
    sw = 4'b0001;
    for (int i = 1; i <= LAT; i++) begin
      step(1);
      exp = (i == LAT) ? 6'b0001_1_0 : 6'b0100_0_1;
      n_checks++;
      if (obs_mci() !== exp) begin
        n_errors++;
        $display("FAIL recover_commit cycle %0d: got %b expected %b", i, obs_mci(), exp);
      end
    end
    step(4);
    n_checks++;
    if (chg_total - c0 !== 1) begin
      n_errors++;
      $display("FAIL illegal_chg_count: got %0d expected 1", chg_total - c0);
    end
  endtask

  task automatic test_bounce_back();
    int c0;
    sw = 4'b1000;
    step(LAT);
    n_checks++;
    if (obs_mci() !== 6'b1000_1_0) begin
      n_errors++;
      $display("FAIL setup_1000: got %b expected %b", obs_mci(), 6'b1000_1_0);
    end
    step(3);
    c0 = chg_total;
    sw = 4'b0000;
    step(2);
    sw = 4'b1000;
    for (int i = 1; i <= 12; i++) begin
      step(1);
      n_checks++;
      if (obs_mci() !== 6'b1000_0_0) begin
        n_errors++;
        $display("FAIL bounce_back cycle %0d: got %b expected %b", i, obs_mci(), 6'b1000_0_0);
      end
    end
    n_checks++;
    if (chg_total !== c0) begin
      n_errors++;
      $display("FAIL bounce_back_chg_count: got %0d expected %0d", chg_total, c0);
    end
  endtask

  task automatic test_reset_mid_settle();
    logic [6:0] exp;
    sw = 4'b1100;
    step(5);
    rst = 1'b1;
    step(1);
    n_checks++;
    if (obs_all() !== 7'b0000_0_0_0) begin
      n_errors++;
      $display("FAIL mid_settle_reset: got %b expected %b", obs_all(), 7'b0000_0_0_0);
    end
    rst = 1'b0;
    for (int i = 1; i <= LAT; i++) begin
      step(1);
      exp = (i == LAT) ? 7'b1100_1_0_0 : 7'b0000_0_0_0;
      n_checks++;
      if (obs_all() !== exp) begin
        n_errors++;
        $display("FAIL post_reset_commit cycle %0d: got %b expected %b", i, obs_all(), exp);
      end
    end
    for (int j = 1; j <= DIV; j++) begin
      step(1);
      exp = {4'b1100, 1'b0, (j == DIV), 1'b0};
      n_checks++;
      if (obs_all() !== exp) begin
        n_errors++;
        $display("FAIL post_reset_tick cycle %0d: got %b expected %b", j, obs_all(), exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_mode();
    test_bounce_to_new();
    test_illegal();
    test_bounce_back();
    test_reset_mid_settle();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
